segre_memory_responder: RTL
===========================

SEGRE_MEMORY_RESPONDER -- requirements
Module: segre_memory_responder

Interface
REQ-001 SHALL have parameter LANE_SIZE, default 128, meaning bits per memory lane (equals the data-cache lane width).
REQ-002 SHALL have parameter ADDR_SIZE, default 32, meaning byte-address width.
REQ-003 SHALL have parameter MEM_LANES, default 1024, meaning number of lanes stored (power of two).
REQ-004 SHALL have parameter LATENCY, default 4, meaning cycles from request accept to response (legal range 1..255).
REQ-005 SHALL have port clk_i, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rsn_i, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port rd_i, input, 1, meaning read request, level, held by the initiator until data_rdy_o.
REQ-008 SHALL have port wr_i, input, 1, meaning write request, level, held by the initiator until data_rdy_o.
REQ-009 SHALL have port addr_i, input, ADDR_SIZE, meaning read byte address.
REQ-010 SHALL have port wr_addr_i, input, ADDR_SIZE, meaning write byte address.
REQ-011 SHALL have port wr_data_i, input, LANE_SIZE, meaning full-lane write data.
REQ-012 SHALL have port data_rdy_o, output, 1, meaning one-cycle completion pulse for the accepted request.
REQ-013 SHALL have port rd_data_o, output, LANE_SIZE, meaning registered read lane.

Function
REQ-014 SHALL compute lane index as byte address bits [log2(LANE_SIZE/8)+log2(MEM_LANES)-1 : log2(LANE_SIZE/8)]; higher bits ignored (wrap modulo MEM_LANES); low offset bits ignored.
REQ-015 SHALL implement FSM IDLE, BUSY, RESPOND; reset state IDLE.
REQ-016 IDLE: when rd_i or wr_i is sampled high at edge t, SHALL latch rd_i, wr_i, both lane indices and wr_data_i, load a counter with LATENCY-1 and enter BUSY.
REQ-017 BUSY: SHALL decrement the counter each edge; at counter 0, SHALL enter RESPOND on the next edge.
REQ-018 data_rdy_o SHALL be high exactly during the cycle following edge t+LATENCY, and only in RESPOND.
REQ-019 On the edge entering RESPOND, SHALL write the latched data to the array if the write was latched.
REQ-020 On the same edge, SHALL load rd_data_o from the array if the read was latched.
REQ-021 Read and write latched together at the same lane: rd_data_o SHALL return the new write data (write before read).
REQ-022 RESPOND SHALL always return to IDLE on the next edge.
REQ-023 New requests SHALL be sampled only in IDLE, so at most one request is outstanding.
REQ-024 Inputs SHALL be ignored in BUSY and RESPOND; deasserting rd_i or wr_i mid-transaction SHALL NOT cancel it.
REQ-025 rd_data_o SHALL hold its value until the next read response; write-only responses SHALL leave it unchanged.
REQ-026 Array contents SHALL NOT be reset; the array SHALL be zero-initialised at time zero.

Reset
REQ-027 Asserting rsn_i low SHALL immediately force state IDLE, counter 0, data_rdy_o 0, rd_data_o 0, and the latched request flags to 0.
REQ-028 Reset mid-transaction SHALL abort it; a latched write not yet committed SHALL be dropped, and no data_rdy_o pulse SHALL follow.
REQ-029 The first request SHALL be sampled at the first rising edge with rsn_i high.

Configuration
REQ-030 With macro SEGRE_MM_STATS_EN defined, the block SHALL add outputs rd_count_o and wr_count_o, 32 bits each.
REQ-031 With SEGRE_MM_STATS_EN defined, each counter SHALL increment once per completed read or write response, saturate at 0xFFFFFFFF and reset to 0.
REQ-032 Without SEGRE_MM_STATS_EN, these ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-033 Write: wr_i=1, wr_addr_i=0x40, wr_data_i=0xA5..A5 at edge 0 -> data_rdy_o high only in cycle after edge 4, rd_data_o unchanged (0).
REQ-034 Read back: rd_i=1, addr_i=0x4C after REQ-033 -> data_rdy_o high 4 edges later, rd_data_o=0xA5..A5 (offset bits ignored).
REQ-035 Read and write together: rd_i=wr_i=1, addr_i=wr_addr_i=0x100, wr_data_i=0x1234 -> single data_rdy_o pulse, rd_data_o=0x1234.
REQ-036 Wrap: write 0x77 to 0x4000 (lane 1024 mod 1024 = 0) -> reading 0x0 returns 0x77.
REQ-037 rd_i held high through response -> exactly one pulse, next accept in IDLE; LATENCY=1 -> pulse in cycle after edge t+1.
REQ-038 rsn_i low 2 cycles after a write accept -> no pulse, and a later read of that lane returns its old value.

Source files
------------

// File: rtl/segre_memory_responder.sv
// Fixed-latency single-outstanding lane memory model for the data cache.
// Optional stats outputs enabled with `define SEGRE_MM_STATS_EN.
//
// Ports:
//   clk_i, rsn_i      clock, async active-low reset
//   rd_i, wr_i        level requests, held until data_rdy_o
//   addr_i            read byte address
//   wr_addr_i         write byte address
//   wr_data_i         full-lane write data
//   data_rdy_o        one-cycle completion pulse
//   rd_data_o         registered read lane
//   rd_count_o        completed reads  (SEGRE_MM_STATS_EN only)
//   wr_count_o        completed writes (SEGRE_MM_STATS_EN only)
module segre_memory_responder #(
  parameter int LANE_SIZE = 128,
  parameter int ADDR_SIZE = 32,
  parameter int MEM_LANES = 1024,
  parameter int LATENCY   = 4
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 rd_i,
  input  logic                 wr_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [ADDR_SIZE-1:0] wr_addr_i,
  input  logic [LANE_SIZE-1:0] wr_data_i,
  output logic                 data_rdy_o,
  output logic [LANE_SIZE-1:0] rd_data_o
`ifdef SEGRE_MM_STATS_EN
  ,
  output logic [31:0]          rd_count_o,
  output logic [31:0]          wr_count_o
`endif
);

  localparam int OFF_W = $clog2(LANE_SIZE / 8);
  localparam int IDX_W = $clog2(MEM_LANES);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } state_t;

  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic [LANE_SIZE-1:0] data;
  } req_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  req_t req_q;
  logic accept;
  logic commit;

  // Array is never reset; it powers up cleared.
  logic [LANE_SIZE-1:0] mem [MEM_LANES] = '{default: '0};

  // Offset bits and bits above the lane index are don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr_i, wr_addr_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_i || wr_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          commit  = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.rd     <= rd_i;
      req_q.wr     <= wr_i;
      req_q.rd_idx <= addr_i[OFF_W +: IDX_W];
      req_q.wr_idx <= wr_addr_i[OFF_W +: IDX_W];
      req_q.data   <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && req_q.wr) begin
      mem[req_q.wr_idx] <= req_q.data;
    end
  end

  // Same-lane read+write returns the new data (write before read).
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_data_o <= '0;
    end else if (commit && req_q.rd) begin
      if (req_q.wr && (req_q.wr_idx == req_q.rd_idx)) begin
        rd_data_o <= req_q.data;
      end else begin
        rd_data_o <= mem[req_q.rd_idx];
      end
    end
  end

  assign data_rdy_o = (state_q == RESPOND);

`ifdef SEGRE_MM_STATS_EN
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (state_q == RESPOND) begin
      if (req_q.rd && (rd_count_o != 32'hFFFF_FFFF)) begin
        rd_count_o <= rd_count_o + 32'd1;
      end
      if (req_q.wr && (wr_count_o != 32'hFFFF_FFFF)) begin
        wr_count_o <= wr_count_o + 32'd1;
      end
    end
  end
`endif

endmodule
